riscv_trace_buffer: RTL and testbench

- Synthesizable retire-trace capture buffer for the single-cycle RISC-V core. It replaces print-style simulation monitoring with on-chip capture.
- Each cycle the core reports a retired instruction: pc, instr, rd_addr, werf, write_data. The block stores these in a DEPTH-entry buffer in one of three capture modes.
- Entries are read out oldest-first through a registered pop interface.

---
 rtl/riscv_trace_buffer.sv | 195 +++++++++++++++++++
 tb/tb_riscv_trace_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_trace_buffer.sv
// riscv_trace_buffer
//   Retire-trace capture buffer for the single-cycle RISC-V core. Each retired
//   instruction {pc, instr, rd, werf, wdata} is stored in a DEPTH-entry buffer
//   under one of three capture modes:
//     0 stop-when-full, 1 circular, 2 trigger window (3 behaves as 0).
//   Entries are read oldest-first through a registered pop interface.
//
// Optional feature (macro TRACE_TIMESTAMP_EN): a 32-bit free-running cycle
//   counter is prepended to each entry as {timestamp, pc, instr, rd, werf, wdata}.
//   arm clears the counter.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   ret_*             retire report: valid, pc, instr, rd, werf, wdata
//   mode              capture mode, sampled on arm
//   trig_pc, post_cnt trigger address and window length (0 means 1)
//   arm               one-cycle pulse: clear buffer/flags, start capture
//   pop               read request; rd_data/rd_valid answer next cycle
//   count/empty/full  occupancy
//   overflow          sticky: entry dropped (mode 0) or overwritten (modes 1/2)
//   triggered         sticky: trigger match occurred
//   frozen            capture stopped (IDLE or DONE)

module riscv_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1,
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = 32 + 3*XLEN + 6
`else
    localparam int ENTRY_W = 3*XLEN + 6
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ret_valid,
    input  logic [XLEN-1:0]    ret_pc,
    input  logic [XLEN-1:0]    ret_instr,
    input  logic [4:0]         ret_rd,
    input  logic               ret_werf,
    input  logic [XLEN-1:0]    ret_wdata,
    input  logic [1:0]         mode,
    input  logic [XLEN-1:0]    trig_pc,
    input  logic [CNT_W-1:0]   post_cnt,
    input  logic               arm,
    input  logic               pop,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               full,
    output logic               overflow,
    output logic               triggered,
    output logic               frozen
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, CAPTURE, POST, DONE} state_t;

    state_t             state;
    logic [1:0]         mode_q;
    logic [CNT_W-1:0]   remaining;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic               wr_req;
    logic               do_pop;
    logic               do_wr;
    logic               ovw;
    logic               drop;
    logic               trig_hit;
    logic [CNT_W-1:0]   post_m1;
    logic [ENTRY_W-1:0] wr_entry;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     ts <= '0;
        else if (arm) ts <= '0;
        else          ts <= ts + 32'd1;
    end

    assign wr_entry = {ts, ret_pc, ret_instr, ret_rd, ret_werf, ret_wdata};
`else
    assign wr_entry = {ret_pc, ret_instr, ret_rd, ret_werf, ret_wdata};
`endif

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_req   = 1'b0;
        do_pop   = 1'b0;
        ovw      = 1'b0;
        drop     = 1'b0;
        do_wr    = 1'b0;
        trig_hit = 1'b0;
        post_m1  = '0;

        wr_req = ret_valid && !arm && (state == CAPTURE || state == POST);
        do_pop = pop && !empty && !arm;
        // Full with no pop freeing a slot: mode 0 drops, modes 1/2 overwrite
        // the oldest entry (the write pointer equals the read pointer here).
        if (wr_req && full && !do_pop) begin
            if (mode_q == 2'd0) drop = 1'b1;
            else                ovw  = 1'b1;
        end
        do_wr    = wr_req && !drop;
        trig_hit = do_wr && state == CAPTURE && mode_q == 2'd2 && ret_pc == trig_pc;
        post_m1  = (post_cnt == '0) ? '0 : post_cnt - ONE_CNT;
    end

    // NOTE: the storage array has no reset; its contents are don't-care until
    // written and leaving it out keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_entry;
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; a pop and a write to the same slot then read
    // the old entry and store the new one in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mode_q    <= 2'd0;
            remaining <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
            frozen    <= 1'b0;
        end else if (arm) begin
            state     <= CAPTURE;
            mode_q    <= (mode == 2'd3) ? 2'd0 : mode;
            remaining <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
            frozen    <= 1'b0;
        end else begin
            rd_valid <= do_pop;
            if (do_pop) rd_data <= mem[rd_ptr];

            if (do_wr)          wr_ptr <= wr_ptr + 1'b1;
            if (do_pop || ovw)  rd_ptr <= rd_ptr + 1'b1;

            // An overwrite keeps count at DEPTH; pop+write leaves it unchanged.
            if (do_wr && !ovw && !do_pop)      count <= count + ONE_CNT;
            else if (do_pop && !(do_wr && !ovw)) count <= count - ONE_CNT;

            if (drop || ovw) overflow <= 1'b1;

            case (state)
                IDLE: frozen <= 1'b1;
                CAPTURE: begin
                    if (trig_hit) begin
                        triggered <= 1'b1;
                        remaining <= post_m1;
                        if (post_m1 == '0) begin
                            state  <= DONE;
                            frozen <= 1'b1;
                        end else begin
                            state <= POST;
                        end
                    end
                end
                POST: begin
                    if (do_wr) begin
                        remaining <= remaining - ONE_CNT;
                        if (remaining == ONE_CNT) begin
                            state  <= DONE;
                            frozen <= 1'b1;
                        end
                    end
                end
                DONE: frozen <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// tb_riscv_trace_buffer
//   Directed testbench for riscv_trace_buffer (XLEN=32, DEPTH=16). Retires use
//   pc-derived field values so every popped entry can be predicted from its pc.
//   Prints "CHECKS <n> ERRORS <m>" at the end.

module tb_riscv_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = 32 + 3*XLEN + 6;
`else
    localparam int EW = 3*XLEN + 6;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             ret_valid;
    logic [XLEN-1:0]  ret_pc;
    logic [XLEN-1:0]  ret_instr;
    logic [4:0]       ret_rd;
    logic             ret_werf;
    logic [XLEN-1:0]  ret_wdata;
    logic [1:0]       mode;
    logic [XLEN-1:0]  trig_pc;
    logic [CNT_W-1:0] post_cnt;
    logic             arm;
    logic             pop;
    logic [EW-1:0]    rd_data;
    logic             rd_valid;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             triggered;
    logic             frozen;

    int checks = 0;
    int errors = 0;

    riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ret_valid (ret_valid),
        .ret_pc    (ret_pc),
        .ret_instr (ret_instr),
        .ret_rd    (ret_rd),
        .ret_werf  (ret_werf),
        .ret_wdata (ret_wdata),
        .mode      (mode),
        .trig_pc   (trig_pc),
        .post_cnt  (post_cnt),
        .arm       (arm),
        .pop       (pop),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .triggered (triggered),
        .frozen    (frozen)
    );

    always #5 clk = ~clk;

    // Stimulus field generators; expectations are rebuilt from the pc.
    function automatic logic [31:0] f_instr(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction
    function automatic logic [31:0] f_wdata(input logic [31:0] pc);
        return pc * 3 + 32'd1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [1:0] m, input logic [31:0] tpc, input logic [CNT_W-1:0] pc_n);
        mode     = m;
        trig_pc  = tpc;
        post_cnt = pc_n;
        arm      = 1'b1;
        tick();
        arm      = 1'b0;
    endtask

    task automatic drive_retire(input logic [31:0] pc);
        ret_valid = 1'b1;
        ret_pc    = pc;
        ret_instr = f_instr(pc);
        ret_rd    = pc[6:2];
        ret_werf  = pc[2];
        ret_wdata = f_wdata(pc);
    endtask

    task automatic retire_range(input int first_pc, input int n);
        for (int i = 0; i < n; i++) begin
            drive_retire(32'(first_pc + 4*i));
            tick();
        end
        ret_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp_pc);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check({tag, ".rd_valid"}, 64'(rd_valid), 64'd1);
        check({tag, ".pc"}, 64'(rd_data[3*XLEN+5 -: XLEN]), 64'(exp_pc));
    endtask

    initial begin
        rst = 1'b0; ret_valid = 1'b0; ret_pc = '0; ret_instr = '0; ret_rd = '0;
        ret_werf = 1'b0; ret_wdata = '0; mode = '0; trig_pc = '0; post_cnt = '0;
        arm = 1'b0; pop = 1'b0;

        // Reset values while held in reset.
        #2;
        check("rst.count", 64'(count), 64'd0);
        check("rst.empty", 64'(empty), 64'd1);
        check("rst.full", 64'(full), 64'd0);
        check("rst.rd_valid", 64'(rd_valid), 64'd0);
        check("rst.rd_data", 64'(rd_data[63:0]), 64'd0);
        check("rst.overflow", 64'(overflow), 64'd0);
        check("rst.triggered", 64'(triggered), 64'd0);
        check("rst.frozen", 64'(frozen), 64'd0);
        #1 rst = 1'b1;
        tick();

        // IDLE: retires are ignored and capture reads as frozen.
        retire_range(100, 2);
        check("idle.count", 64'(count), 64'd0);
        check("idle.frozen", 64'(frozen), 64'd1);

        // Mode 0: stop when full.
        do_arm(2'd0, '0, '0);
        check("m0.arm_frozen", 64'(frozen), 64'd0);
        retire_range(0, 20);
        check("m0.count", 64'(count), 64'd16);
        check("m0.full", 64'(full), 64'd1);
        check("m0.overflow", 64'(overflow), 64'd1);
        pop_expect("m0.pop0", 32'd0);
        check("m0.instr0", 64'(rd_data[2*XLEN+5 -: XLEN]), 64'(f_instr(32'd0)));
        check("m0.wdata0", 64'(rd_data[XLEN-1:0]), 64'(f_wdata(32'd0)));
        check("m0.count15", 64'(count), 64'd15);
        for (int i = 1; i < 16; i++) pop_expect($sformatf("m0.pop%0d", i), 32'(4*i));
        check("m0.rd_pc_field", 64'(rd_data[3*XLEN+5 -: XLEN]), 64'd60);
        check("m0.rd_rd_werf", 64'(rd_data[XLEN+5:XLEN]), 64'({5'd15, 1'b1}));
        check("m0.empty", 64'(empty), 64'd1);
        // Pop on empty: no rd_valid, data holds.
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("m0.pop_empty_valid", 64'(rd_valid), 64'd0);
        check("m0.pop_empty_hold", 64'(rd_data[3*XLEN+5 -: XLEN]), 64'd60);

        // Mode 1: circular, oldest entries overwritten.
        do_arm(2'd1, '0, '0);
        check("m1.arm_overflow", 64'(overflow), 64'd0);
        retire_range(0, 20);
        check("m1.overflow", 64'(overflow), 64'd1);
        check("m1.count", 64'(count), 64'd16);
        check("m1.frozen", 64'(frozen), 64'd0);
        for (int i = 0; i < 16; i++) pop_expect($sformatf("m1.pop%0d", i), 32'(16 + 4*i));
        check("m1.empty", 64'(empty), 64'd1);

        // Mode 1: pop and retire together while exactly full.
        do_arm(2'd1, '0, '0);
        retire_range(0, 16);
        check("pw.full", 64'(full), 64'd1);
        check("pw.overflow_pre", 64'(overflow), 64'd0);
        drive_retire(32'd64);
        pop_expect("pw.pop", 32'd0);
        ret_valid = 1'b0;
        check("pw.count", 64'(count), 64'd16);
        check("pw.overflow", 64'(overflow), 64'd0);
        pop_expect("pw.next", 32'd4);
        check("pw.count15", 64'(count), 64'd15);

        // Mode 2: trigger at pc 40 with a 4-entry window; mode input changed
        // after arm must not matter.
        do_arm(2'd2, 32'd40, CNT_W'(4));
        mode = 2'd0;
        for (int i = 0; i < 20; i++) begin
            drive_retire(32'(4*i));
            tick();
            if (i == 9)  check("m2.pre_trig", 64'(triggered), 64'd0);
            if (i == 10) check("m2.triggered", 64'(triggered), 64'd1);
            if (i == 12) check("m2.not_frozen", 64'(frozen), 64'd0);
            if (i == 13) check("m2.frozen", 64'(frozen), 64'd1);
        end
        ret_valid = 1'b0;
        check("m2.count", 64'(count), 64'd14);
        check("m2.overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 14; i++) pop_expect($sformatf("m2.pop%0d", i), 32'(4*i));
        check("m2.empty", 64'(empty), 64'd1);
        check("m2.frozen_after", 64'(frozen), 64'd1);

        // Mode 2 with post_cnt 0: the trigger entry alone closes the window.
        do_arm(2'd2, 32'd8, '0);
        retire_range(0, 6);
        check("p0.count", 64'(count), 64'd3);
        check("p0.frozen", 64'(frozen), 64'd1);

        // Asynchronous reset in the middle of POST.
        do_arm(2'd2, 32'd8, CNT_W'(8));
        retire_range(0, 5);
        check("mr.triggered", 64'(triggered), 64'd1);
        check("mr.frozen", 64'(frozen), 64'd0);
        pop_expect("mr.pop", 32'd0);
        #1 rst = 1'b0;
        #1;
        check("mr.count", 64'(count), 64'd0);
        check("mr.empty", 64'(empty), 64'd1);
        check("mr.rd_valid", 64'(rd_valid), 64'd0);
        check("mr.rd_data", 64'(rd_data[63:0]), 64'd0);
        check("mr.triggered0", 64'(triggered), 64'd0);
        check("mr.frozen0", 64'(frozen), 64'd0);
        check("mr.overflow", 64'(overflow), 64'd0);
        #1 rst = 1'b1;
        tick();

`ifdef TRACE_TIMESTAMP_EN
        // Timestamps: arm, 3 idle cycles, then two back-to-back retires.
        do_arm(2'd0, '0, '0);
        tick();
        tick();
        tick();
        retire_range(200, 2);
        pop_expect("ts.pop0", 32'd200);
        check("ts.first", 64'(rd_data[EW-1 -: 32]), 64'd3);
        pop_expect("ts.pop1", 32'd204);
        check("ts.second", 64'(rd_data[EW-1 -: 32]), 64'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
